// File: rtl/dmem_pkg.sv
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared types and constants for the dmem_ctrl data memory slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WAIT_MAX = 7;

endpackage

`default_nettype wire

// File: rtl/dmem_align.sv
// ============================================================================
// Module  : dmem_align
// Brief   : Combinational byte-lane steering for stores and load extraction /
//           sign or zero extension.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_align
  import dmem_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata
);

  logic [31:0] w_sh;

  always_comb begin
    o_be    = 4'b0000;
    o_wword = i_wdata;
    o_rdata = 32'h0;
    w_sh    = i_rword >> {i_off, 3'b000};
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_off;
        o_wword = {4{i_wdata[7:0]}};
        o_rdata = i_unsigned ? {24'h0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
      end
      SZ_H: begin
        o_be    = 4'b0011 << i_off;
        o_wword = {2{i_wdata[15:0]}};
        o_rdata = i_unsigned ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
      end
      SZ_W: begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        o_rdata = w_sh;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = 32'h0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module  : dmem_ctrl
// Brief   : Handshaked byte-addressed data memory with wait states and fault
//           detection. Optional macro DMEM_RANGE_CHK_EN faults out-of-range
//           addresses instead of letting them alias.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int         c_wait_eff  = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;
  localparam logic [2:0] c_wait_load = (c_wait_eff > 0) ? 3'(c_wait_eff - 1) : 3'd0;

  logic [31:0] r_mem [0:(1<<AW)-1];

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic          w_accept;
  logic          w_range_err;
  logic          w_err;
  logic          w_mem_we;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  size_e         w_size;
  logic [3:0]    w_be;
  logic [31:0]   w_wword;
  logic [31:0]   w_rword;
  logic [31:0]   w_ld_data;

  assign w_idx  = i_req_addr[AW+1:2];
  assign w_off  = i_req_addr[1:0];
  assign w_size = size_e'(i_req_size);

`ifdef DMEM_RANGE_CHK_EN
  assign w_range_err = |i_req_addr[31:AW+2];
`else
  // Upper address bits are intentionally ignored so accesses wrap.
  logic w_unused_addr;
  assign w_unused_addr = ^i_req_addr[31:AW+2];
  assign w_range_err   = 1'b0;
`endif

  assign w_err = (w_size == SZ_X)
               | ((w_size == SZ_H) & w_off[0])
               | ((w_size == SZ_W) & (w_off != 2'd0))
               | w_range_err;

  assign o_req_ready = (r_state == IDLE) | ((r_state == RESP) & i_rsp_ready);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_mem_we    = w_accept & i_req_we & ~w_err;
  assign w_rword     = r_mem[w_idx];

  dmem_align u_align (
    .i_size     (w_size),
    .i_off      (w_off),
    .i_unsigned (i_req_unsigned),
    .i_wdata    (i_req_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_ld_data)
  );

  // Storage is not reset; a store is committed at its accept edge.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_mem_we && w_be[k]) begin
        r_mem[w_idx][8*k +: 8] <= w_wword[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_rsp_data <= 32'h0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_rsp_data <= (i_req_we | w_err) ? 32'h0 : w_ld_data;
        r_rsp_err  <= w_err;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (c_wait_eff == 0) ? RESP : WAIT;
          w_cnt_nxt   = c_wait_load;
        end
      end
      WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          if (w_accept) begin
            w_state_nxt = (c_wait_eff == 0) ? RESP : WAIT;
            w_cnt_nxt   = c_wait_load;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = (r_state == RESP) ? r_rsp_data : 32'h0;
  assign o_rsp_err   = (r_state == RESP) ? r_rsp_err  : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module  : tb_dmem_ctrl
// Brief   : Self-checking bench for dmem_ctrl at WAIT_CYCLES=0 and 3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;

  logic        rr0, rv0, re0, rr1, rv1, re1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  dmem_ctrl #(.AW(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid & ~sel), .o_req_ready(rr0),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rv0), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd0), .o_rsp_err(re0)
  );

  dmem_ctrl #(.AW(AW), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid & sel), .o_req_ready(rr1),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rv1), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rd1), .o_rsp_err(re1)
  );

  wire        d_ready = sel ? rr1 : rr0;
  wire        d_valid = sel ? rv1 : rv0;
  wire [31:0] d_rdata = sel ? rd1 : rd0;
  wire        d_err   = sel ? re1 : re0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: byte-array memory plus one outstanding response.
  logic [7:0]  mem_m [2][1 << (AW + 2)];
  bit          m_valid = 0, m_busy = 0, m_err = 0, m_acc;
  int          m_cnt = 0;
  logic [31:0] m_data = 32'h0;

  function automatic int wait_of();
    return sel ? 3 : 0;
  endfunction

  function automatic bit m_ready();
    return (!m_busy && !m_valid) || (m_valid && rsp_ready);
  endfunction

  function automatic void m_access();
    bit          err;
    int          a, nb;
    logic [31:0] w;
    err = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0);
`ifdef DMEM_RANGE_CHK_EN
    if (req_addr >= 32'(1 << (AW + 2))) err = 1;
`endif
    a  = int'(req_addr % 32'(1 << (AW + 2)));
    nb = 1 << req_size;
    m_err  = err;
    m_data = 32'h0;
    if (!err) begin
      if (req_we) begin
        for (int i = 0; i < nb; i++) mem_m[sel][a + i] = req_wdata[8*i +: 8];
      end else begin
        w = 32'h0;
        for (int i = 0; i < nb; i++) w[8*i +: 8] = mem_m[sel][a + i];
        if (!req_unsigned && nb < 4 && w[8*nb-1])
          for (int i = nb; i < 4; i++) w[8*i +: 8] = 8'hFF;
        m_data = w;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0;
      m_busy  = 0;
    end else begin
      m_acc = req_valid && m_ready();
      if (m_valid && rsp_ready) m_valid = 0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy  = 0;
          m_valid = 1;
        end
      end
      if (m_acc) begin
        m_access();
        if (wait_of() == 0) m_valid = 1;
        else begin
          m_busy = 1;
          m_cnt  = wait_of();
        end
      end
    end
  end

  // Per-cycle compare plus capture of consumed responses.
  logic [32:0] q_rsp[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_valid", {31'h0, d_valid}, {31'h0, m_valid});
      chk("req_ready", {31'h0, d_ready}, {31'h0, m_ready()});
      chk("rsp_rdata", d_rdata, m_valid ? m_data : 32'h0);
      chk("rsp_err", {31'h0, d_err}, {31'h0, (m_valid ? m_err : 1'b0)});
      if (d_valid && rsp_ready) begin
        q_rsp.push_back({d_err, d_rdata});
        q_cyc.push_back(cyc);
      end
    end
  end

  int acc_cyc;

  task automatic op(input bit we, input logic [1:0] sz, input bit uns,
                    input logic [31:0] addr, input logic [31:0] wd);
    bit got;
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (d_ready) begin
        got = 1;
        acc_cyc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input string name, input bit e, input logic [31:0] d);
    logic [32:0] r;
    if (q_rsp.size() == 0) begin
      chk({name, "_missing"}, 32'h0, 32'h1);
    end else begin
      r = q_rsp.pop_front();
      chk({name, "_err"}, {31'h0, r[32]}, {31'h0, e});
      chk({name, "_data"}, r[31:0], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit          seen;
    int          vcyc;

    step(3);
    rst_n = 1;
    @(negedge clk);
    chk("reset_rsp_valid", {31'h0, rv0}, 32'h0);
    chk("reset_req_ready", {31'h0, rr0}, 32'h1);
    chk("reset_rdata", rd0, 32'h0);
    chk("reset_err", {31'h0, re0}, 32'h0);
    step(1);

    // WAIT_CYCLES=0, back-to-back stream with rsp_ready high
    op(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    op(0, 2'd2, 0, 32'h10, 32'h0);
    op(0, 2'd0, 0, 32'h13, 32'h0);
    op(0, 2'd0, 1, 32'h13, 32'h0);
    op(0, 2'd1, 0, 32'h12, 32'h0);
    op(1, 2'd0, 0, 32'h11, 32'h55);
    op(0, 2'd2, 0, 32'h10, 32'h0);
    op(1, 2'd2, 0, 32'h12, 32'h11111111);
    op(0, 2'd2, 0, 32'h10, 32'h0);
    op(0, 2'd1, 0, 32'h13, 32'h0);
    op(0, 2'd3, 0, 32'h10, 32'h0);
    step(3);
    expect_rsp("sw", 0, 32'h0);
    expect_rsp("lw", 0, 32'hDEADBEEF);
    expect_rsp("lb", 0, 32'hFFFFFFDE);
    expect_rsp("lbu", 0, 32'h000000DE);
    expect_rsp("lh", 0, 32'hFFFFDEAD);
    expect_rsp("sb", 0, 32'h0);
    expect_rsp("lw_sb", 0, 32'hDEAD55EF);
    expect_rsp("sw_mis", 1, 32'h0);
    expect_rsp("lw_after_mis", 0, 32'hDEAD55EF);
    expect_rsp("lh_mis", 1, 32'h0);
    expect_rsp("size3", 1, 32'h0);

    // Alternating SW/LW at 0x20, one response per cycle
    q_rsp.delete(); q_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      d = 32'h11111111 * (i + 1);
      op(1, 2'd2, 0, 32'h20, d);
      op(0, 2'd2, 0, 32'h20, 32'h0);
    end
    step(3);
    if (q_cyc.size() == 8) chk("b2b_span", 32'(q_cyc[7] - q_cyc[0]), 32'd7);
    else chk("b2b_count", 32'(q_cyc.size()), 32'd8);
    expect_rsp("b2b_sw0", 0, 32'h0);
    expect_rsp("b2b_lw0", 0, 32'h11111111);
    for (int i = 1; i < 4; i++) begin
      expect_rsp("b2b_sw", 0, 32'h0);
      expect_rsp("b2b_lw", 0, 32'h11111111 * (i + 1));
    end

    // Address range / alias
    q_rsp.delete();
    op(1, 2'd2, 0, 32'h0, 32'h01234567);
    op(0, 2'd2, 0, 32'h400, 32'h0);
    step(3);
    expect_rsp("sw_0", 0, 32'h0);
`ifdef DMEM_RANGE_CHK_EN
    expect_rsp("lw_range", 1, 32'h0);
`else
    expect_rsp("lw_alias", 0, 32'h01234567);
`endif

    // WAIT_CYCLES=3 instance
    sel = 1;
    q_rsp.delete();
    step(1);
    op(1, 2'd2, 0, 32'h40, 32'hCAFEF00D);
    step(6);
    rsp_ready = 0;
    op(0, 2'd2, 0, 32'h40, 32'h0);
    seen = 0; vcyc = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (d_valid) begin seen = 1; vcyc = cyc; end
    end
    chk("wait3_latency", 32'(vcyc - acc_cyc), 32'd4);
    step(2);
    rsp_ready = 1;
    step(2);
    expect_rsp("w3_sw", 0, 32'h0);
    expect_rsp("w3_lw", 0, 32'hCAFEF00D);

    // Reset during WAIT: accepted store persists, pending load dropped
    op(1, 2'd2, 0, 32'h44, 32'h13572468);
    rst_n = 0;
    step(2);
    rst_n = 1;
    op(0, 2'd2, 0, 32'h40, 32'h0);
    rst_n = 0;
    step(2);
    rst_n = 1;
    @(negedge clk);
    chk("rst_wait_rsp_valid", {31'h0, rv1}, 32'h0);
    chk("rst_wait_req_ready", {31'h0, rr1}, 32'h1);
    step(1);
    q_rsp.delete();
    op(0, 2'd2, 0, 32'h44, 32'h0);
    step(6);
    expect_rsp("lw_after_rst", 0, 32'h13572468);
    chk("no_extra_rsp", 32'(q_rsp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, handshaked data memory for the core's load/store path.
- Byte-addressed, with byte, halfword and word accesses and sign or zero extension on loads.
- Detects misaligned and illegal accesses and flags them.
- Adds configurable read latency (wait states) and valid/ready request and response channels, so the LSU can stall on memory.

Parameters:
- AW, 8: word-address width; depth = 2^AW words; byte address span = 2^(AW+2).
- WAIT_CYCLES, 0: extra wait states between request accept and response, range 0..7.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access faulted

Behaviour:
- States: IDLE, WAIT, RESP. Reset: IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory contents are not reset.
- Handshakes:
  - req_ready = (state==IDLE) | (state==RESP & rsp_ready).
  - A request is accepted on req_valid & req_ready.
  - A response is consumed on rsp_valid & rsp_ready.
- Accept actions:
  - Decode index = req_addr[AW+1:2] and offset = req_addr[1:0].
  - err = (size==3) | (size==1 & off[0]) | (size==2 & off!=0).
  - Store without err: write the selected bytes in the accept cycle via byte enables. Byte: lane=off. Half: lanes off, off+1. Word: all lanes. Other lanes are unchanged.
  - Load without err: read the word in the accept cycle, then shift right by 8*off, mask to the access size and extend per req_unsigned. Register the result into the response data holding register.
  - err: no memory write; data=0, err=1.
- Transitions:
  - Accept with WAIT_CYCLES=0 goes to RESP.
  - Accept with WAIT_CYCLES>0 loads counter=WAIT_CYCLES-1 and goes to WAIT.
  - WAIT: counter==0 goes to RESP, else decrement.
- Output timing:
  - rsp_valid=1 exactly in RESP. rsp_rdata and rsp_err are driven from the holding register only in RESP and are 0 otherwise.
  - First rsp_valid comes WAIT_CYCLES+1 cycles after the accept edge.
- RESP:
  - With rsp_ready=0, hold all outputs stable.
  - With rsp_ready=1 and a new request, accept it in the same cycle (back-to-back); next state per the transitions above.
  - With rsp_ready=1 and no request, go to IDLE.
  - Full throughput is one access per WAIT_CYCLES+1 cycles with rsp_ready tied high.
- Load after store in the same back-to-back cycle: the store was written at its own earlier accept, so the load sees the new data.
- Reset mid-operation: a store already accepted stays written; a pending load response is dropped; state returns to IDLE.
- Inputs other than req_valid are don't-care when no accept occurs.

Optional Feature:
- Macro DMEM_RANGE_CHK_EN.
- Defined: req_addr[31:AW+2] != 0 adds to err, so a store is suppressed and the response is err=1, data=0.
- Undefined: the upper address bits are ignored and addresses alias (wrap) modulo 2^(AW+2).

Decomposition:
- dmem_pkg holds:
  - size_e (SZ_B=2'd0, SZ_H=2'd1, SZ_W=2'd2, SZ_X=2'd3)
  - state_e (IDLE, WAIT, RESP)
  - constant WAIT_MAX=7
- Sub-module dmem_align: purely combinational.
  - Store side: given size, offset and wdata, produces the 4-bit byte enable and the lane-replicated write word.
  - Load side: given size, offset, unsigned flag and raw word, produces extended rdata.
- dmem_ctrl holds the FSM, counter, RAM and response registers.

Test Plan:
- WAIT_CYCLES=0: SW 0xDEADBEEF@0x10, then LW@0x10 → rdata=0xDEADBEEF, err=0, rsp_valid 1 cycle after accept; LB@0x13 → 0xFFFFFFDE; LBU@0x13 → 0x000000DE; LH@0x12 → 0xFFFFDEAD.
- SB 0x55@0x11 over 0xDEADBEEF, then LW@0x10 → 0xDEAD55EF (other lanes preserved).
- Misaligned: SW@0x12 then LW@0x10 → store gets err=1 and memory is unchanged; LH@0x13 → err=1, rdata=0; size=3 → err=1.
- WAIT_CYCLES=3, rsp_ready held low 5 cycles: rsp_valid rises 4 cycles after accept, outputs stable, req_ready=0 until rsp_ready=1.
- Back-to-back with rsp_ready=1 and WAIT_CYCLES=0: alternating SW/LW to 0x20 every cycle → one response per cycle, each load returns the preceding store's data.
- Reset asserted in WAIT after an LW → rsp_valid=0, req_ready=1 after release. With DMEM_RANGE_CHK_EN, LW@0x400 (AW=8) → err=1; without the macro, LW@0x400 returns the word at 0x0.
